lr1_sweep_sequencer: RTL and testbench

//   Hardware stimulus sequencer for the LR1 combinational datapath (SW[11:0] -> LED[11:0]).
//   On START it sweeps a 4-bit code through all 16 values and drives SW_OUT = {CODE,CODE,CODE}.
//   It holds each code for a programmable dwell, then captures the datapath's LED response.

---
 rtl/lr1_sweep_sequencer_pkg.sv | 24 ++
 rtl/lr1_sweep_sequencer_if.sv | 31 +++
 rtl/lr1_dwell_timer.sv | 32 +++
 rtl/lr1_sweep_sequencer.sv | 140 ++++++++++++++
 tb/tb_lr1_sweep_sequencer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/lr1_sweep_sequencer_pkg.sv
// Shared definitions for the LR1 sweep sequencer: FSM states, code limits, bus widths.
// Pure declarations; no latency.
// No handshakes.
package lr1_sweep_sequencer_pkg;

  localparam int SW_W  = 12;
  localparam int LED_W = 12;

  localparam logic [3:0] CODE_MIN = 4'h0;
  localparam logic [3:0] CODE_MAX = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FINISH  = 2'd3
  } state_t;

  // Stimulus word seen by the datapath: the code replicated across all three nibbles.
  function automatic logic [SW_W-1:0] rep3(input logic [3:0] code);
    return {code, code, code};
  endfunction

endpackage

// File: rtl/lr1_sweep_sequencer_if.sv
// Control/stimulus/capture bundle between the board controls, the sequencer and the LR1 datapath.
// Wires only; no latency.
// No backpressure: start is a single-cycle request, cap_valid a single-cycle pulse.
interface lr1_sweep_sequencer_if;
  import lr1_sweep_sequencer_pkg::*;

  logic             start;
  logic             pause;
  logic             dir;
  logic [LED_W-1:0] led_in;
  logic [SW_W-1:0]  sw_out;
  logic [3:0]       code;
  logic             busy;
  logic             done;
  logic             cap_valid;
  logic [LED_W-1:0] cap_data;
  logic [SW_W-1:0]  sig;

  // Controls and datapath response side.
  modport master (
    output start, pause, dir, led_in,
    input  sw_out, code, busy, done, cap_valid, cap_data, sig
  );

  // Sequencer side.
  modport slave (
    input  start, pause, dir, led_in,
    output sw_out, code, busy, done, cap_valid, cap_data, sig
  );

endinterface

// File: rtl/lr1_dwell_timer.sv
// Loadable down-counter that times how long each code is held before capture.
// Load takes effect on the next edge; zero flag is combinational from the count.
// hold freezes the count; the count also rests at zero until reloaded.
module lr1_dwell_timer #(
  parameter int CNT_W        = 16,
  parameter int DWELL_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic hold,
  output logic zero
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Reload has priority; otherwise count down unless held or already at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (!hold && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lr1_sweep_sequencer.sv
// Sweeps a 4-bit code over all 16 values into the LR1 datapath, capturing LED_IN after each dwell.
// Each code lasts DWELL_CYCLES settle cycles plus one capture cycle; DONE rises 16*(DWELL_CYCLES+1) edges after START is sampled.
// PAUSE stretches the settle phase; START is ignored while busy. Optional signature: LR1_SIGNATURE_EN.
module lr1_sweep_sequencer
  import lr1_sweep_sequencer_pkg::*;
#(
  parameter int DWELL_CYCLES = 20,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  lr1_sweep_sequencer_if.slave   bus
);

  state_t     state, state_nxt;
  logic [1:0] rst_sync;
  logic       rst_int;
  logic       up;
  logic       start_acc;
  logic       load;
  logic       capture;
  logic       last_code;
  logic       timer_zero;
  logic [3:0] code_step;
  logic [3:0] start_code;

  // Reset asserts immediately and releases two edges after RST falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_sync <= 2'b11;
    end else begin
      rst_sync <= {rst_sync[0], 1'b0};
    end
  end

  assign rst_int = rst_sync[1];

  lr1_dwell_timer #(
    .CNT_W        (CNT_W),
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_dwell_timer (
    .clk  (clk),
    .rst  (rst_int),
    .load (load),
    .hold (bus.pause),
    .zero (timer_zero)
  );

  assign last_code  = up ? (bus.code == CODE_MAX) : (bus.code == CODE_MIN);
  assign code_step  = up ? (bus.code + 4'd1) : (bus.code - 4'd1);
  assign start_code = bus.dir ? CODE_MIN : CODE_MAX;

  // State register.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    load      = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE, ST_FINISH: begin
        if (bus.start) begin
          state_nxt = ST_SETTLE;
          start_acc = 1'b1;
          load      = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!bus.pause && timer_zero) begin
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        if (last_code) begin
          state_nxt = ST_FINISH;
        end else begin
          state_nxt = ST_SETTLE;
          load      = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Code, stimulus, status flags and capture register.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      up            <= 1'b0;
      bus.code      <= '0;
      bus.sw_out    <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.cap_valid <= 1'b0;
      bus.cap_data  <= '0;
    end else begin
      bus.cap_valid <= capture;
      if (start_acc) begin
        up         <= bus.dir;
        bus.code   <= start_code;
        bus.sw_out <= rep3(start_code);
        bus.busy   <= 1'b1;
        bus.done   <= 1'b0;
      end else if (capture) begin
        bus.cap_data <= bus.led_in;
        if (last_code) begin
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end else begin
          bus.code   <= code_step;
          bus.sw_out <= rep3(code_step);
        end
      end
    end
  end

`ifdef LR1_SIGNATURE_EN
  // Rotate-XOR signature folded over every captured response, cleared on each new sweep.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      bus.sig <= '0;
    end else if (start_acc) begin
      bus.sig <= '0;
    end else if (capture) begin
      bus.sig <= {bus.sig[SW_W-2:0], bus.sig[SW_W-1]} ^ bus.led_in;
    end
  end
`else
  assign bus.sig = '0;
`endif

endmodule

// File: tb/tb_lr1_sweep_sequencer.sv
// Self-checking bench for lr1_sweep_sequencer with DWELL_CYCLES=4 and LED_IN = ~SW_OUT.
// Randomised direction, pause placement/length and restart timing against a sweep-level model.
// Signature expectation follows LR1_SIGNATURE_EN.
module tb_lr1_sweep_sequencer;

  localparam int DW     = 4;
  localparam int PERIOD = DW + 1;
  localparam int LAT    = 16 * PERIOD + 1;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  lr1_sweep_sequencer_if bus ();

  lr1_sweep_sequencer #(
    .DWELL_CYCLES (DW),
    .CNT_W        (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.led_in = ~bus.sw_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] rot_xor(input logic [11:0] s, input logic [11:0] d);
    return {s[10:0], s[11]} ^ d;
  endfunction

  // One sweep: start, optional pause on code index pidx, optional ignored START, optional abort by RST.
  task automatic run_sweep(input logic d, input int pidx, input int plen,
                           input int restart_at, input int abort_at);
    logic [3:0]  codes[$];
    int          lens[$];
    logic [11:0] caps[$];
    int          done_at = 0;
    int          sw_bad = 0;
    int          busy_bad = 0;
    int          seq_bad = 0;
    int          cap_bad = 0;
    int          hold_bad = 0;
    int          extra;
    logic [3:0]  ec;
    logic [3:0]  end_code;
    logic [11:0] ecap;
    logic [11:0] esig;

    extra = (pidx >= 0) ? plen : 0;
    @(negedge clk);
    bus.dir   = d;
    bus.start = 1'b1;
    bus.pause = 1'b0;
    for (int c = 1; c <= LAT + 60; c++) begin
      @(negedge clk);
      bus.start = (restart_at != 0 && c == restart_at);
      bus.pause = (pidx >= 0 && c + 1 >= 2 + PERIOD * pidx && c + 1 <= 1 + PERIOD * pidx + plen);
      if (abort_at != 0 && c == abort_at) begin
        bus.start = 1'b0;
        bus.pause = 1'b0;
        check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_code", {28'd0, bus.code}, 32'd0);
        check("abort_sw_out", {20'd0, bus.sw_out}, 32'd0);
        check("abort_flags", {29'd0, bus.busy, bus.done, bus.cap_valid}, 32'd0);
        check("abort_cap_sig", {8'd0, bus.cap_data, bus.sig}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_stays_idle", {29'd0, bus.busy, bus.done, bus.cap_valid}, 32'd0);
        return;
      end
      if (bus.cap_valid) caps.push_back(bus.cap_data);
      if (bus.sw_out !== {3{bus.code}}) sw_bad++;
      if (bus.done) begin
        done_at = c;
        break;
      end
      if (!bus.busy) busy_bad++;
      if (codes.size() == 0 || codes[$] !== bus.code) begin
        codes.push_back(bus.code);
        lens.push_back(1);
      end else begin
        lens[$] = lens[$] + 1;
      end
    end
    bus.start = 1'b0;
    bus.pause = 1'b0;

    check("done_latency", done_at, LAT + extra);
    check("busy_during_sweep", busy_bad, 0);
    check("sw_out_tracks_code", sw_bad, 0);
    check("code_run_count", codes.size(), 16);
    check("cap_count", caps.size(), 16);

    esig = '0;
    for (int i = 0; i < 16; i++) begin
      ec   = d ? 4'(i) : 4'(15 - i);
      ecap = ~{ec, ec, ec};
      esig = rot_xor(esig, ecap);
      if (i < codes.size()) begin
        if (codes[i] !== ec) seq_bad++;
        if (lens[i] != PERIOD + ((i == pidx) ? plen : 0)) seq_bad++;
      end
      if (i < caps.size() && caps[i] !== ecap) cap_bad++;
    end
    check("code_sequence_and_dwell", seq_bad, 0);
    check("cap_values", cap_bad, 0);
    if (caps.size() > 0) check("cap_first", {20'd0, caps[0]}, d ? 32'hFFF : 32'h000);
`ifdef LR1_SIGNATURE_EN
    check("signature", {20'd0, bus.sig}, {20'd0, esig});
`else
    check("signature_off", {20'd0, bus.sig}, 32'd0);
`endif

    end_code = d ? 4'hF : 4'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.code !== end_code || bus.sw_out !== {3{end_code}}) hold_bad++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.cap_valid !== 1'b0) hold_bad++;
    end
    check("finish_hold", hold_bad, 0);
  endtask

  initial begin
    int idle_bad;
    int pidx;
    int plen;
    logic d;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.dir   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.code, bus.sw_out, bus.busy, bus.done, bus.cap_valid}, 32'd0);
    check("reset_cap_sig", {8'd0, bus.cap_data, bus.sig}, 32'd0);
    rst = 1'b0;

    idle_bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if ({bus.code, bus.sw_out, bus.busy, bus.done, bus.cap_valid, bus.cap_data, bus.sig} !== '0)
        idle_bad++;
    end
    check("idle_outputs_zero", idle_bad, 0);

    run_sweep(1'b0, -1, 0, 0, 0);
    run_sweep(1'b1, -1, 0, 0, 0);

    pidx = int'($urandom_range(0, 15));
    d    = 1'($urandom);
    run_sweep(d, pidx, 7, 0, 0);

    pidx = int'($urandom_range(0, 15));
    plen = int'($urandom_range(1, 12));
    d    = 1'($urandom);
    run_sweep(d, pidx, plen, 0, 0);

    d = 1'($urandom);
    run_sweep(d, -1, 0, 30, 0);
    d = 1'($urandom);
    run_sweep(d, -1, 0, 0, 40);
    d = 1'($urandom);
    run_sweep(d, -1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
